// File: rtl/pipe_pkg.sv
// Shared types for the fetch->decode pipeline boundary: payload layout, stage states, bubble value.
package pipe_pkg;

    localparam int          PIPE_ADDR_W      = 32;
    localparam int          PIPE_INST_W      = 32;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [PIPE_ADDR_W-1:0] addr;
        logic [PIPE_INST_W-1:0] inst;
    } fd_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for perf events; increments once per cycle inc is high, holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_decode_pipe_reg.sv
// Elastic fetch->decode register: 1-cycle latency, optional skid entry so in_ready comes from a flop.
// Flush empties the stage; an empty stage shows a NOP bubble at addr 0.
module fetch_decode_pipe_reg
    import pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEFAULT_NOP_INST),
    parameter bit                SKID_EN  = 1'b1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } payload_t;

    stage_state_e state_q;
    payload_t     head_q;
    payload_t     skid_q;
    payload_t     in_pld;
    logic         in_ready_q;
    logic         in_xfer;
    logic         out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign in_pld    = '{addr: in_addr, inst: in_inst};

    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            // Without a skid slot we may only accept when the head is leaving.
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else if (flush_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        head_q  <= in_pld;
                        state_q <= ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (in_xfer && out_xfer) begin
                        head_q <= in_pld;
                    end else if (in_xfer) begin
                        skid_q     <= in_pld;
                        state_q    <= ST_SKID;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        head_q     <= skid_q;
                        state_q    <= ST_MAIN;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign out_addr = out_valid ? head_q.addr : '0;
    assign out_inst = out_valid ? head_q.inst : NOP_INST;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_i),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_fetch_decode_pipe_reg.sv
// Bench for fetch_decode_pipe_reg: skid (A), 4-bit counter (B) and no-skid (C) variants share stimulus.
module tb_fetch_decode_pipe_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_inst = '0;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_addr, a_out_inst;
    logic [15:0] a_stall, a_flush;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_addr, b_out_inst;
    logic [3:0]  b_stall, b_flush;
    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_addr, c_out_inst;
    logic [15:0] c_stall, c_flush;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each stage is a FIFO of accepted payloads (capacity 2 with skid, 1 without).
    fd_payload_t qa[$];
    fd_payload_t qc[$];
    int unsigned m_stall_a, m_flush_a, m_stall_b, m_flush_b, m_stall_c, m_flush_c;

    always #5 clk = ~clk;

    fetch_decode_pipe_reg dut_a (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_addr(in_addr), .in_inst(in_inst), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_addr(a_out_addr), .out_inst(a_out_inst), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    fetch_decode_pipe_reg #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_addr(in_addr), .in_inst(in_inst), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_addr(b_out_addr), .out_inst(b_out_inst), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    fetch_decode_pipe_reg #(.SKID_EN(1'b0)) dut_c (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_addr(in_addr), .in_inst(in_inst), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_addr(c_out_addr), .out_inst(c_out_inst), .stall_cnt(c_stall), .flush_cnt(c_flush)
    );

    function automatic int unsigned sat_inc(input int unsigned v, input int w);
        return (v < (32'd1 << w) - 1) ? v + 1 : v;
    endfunction

    function automatic logic [31:0] ea_addr();
        return (qa.size() > 0) ? qa[0].addr : 32'h0;
    endfunction
    function automatic logic [31:0] ea_inst();
        return (qa.size() > 0) ? qa[0].inst : 32'h13;
    endfunction
    function automatic logic [31:0] ec_addr();
        return (qc.size() > 0) ? qc[0].addr : 32'h0;
    endfunction
    function automatic logic [31:0] ec_inst();
        return (qc.size() > 0) ? qc[0].inst : 32'h13;
    endfunction

    task automatic model_clear();
        qa.delete();
        qc.delete();
        m_stall_a = 0; m_flush_a = 0; m_stall_b = 0;
        m_flush_b = 0; m_stall_c = 0; m_flush_c = 0;
    endtask

    // Advance one clock: evaluate handshakes on pre-edge inputs, update model at the edge.
    task automatic tick();
        bit va, vc, ixa, oxa, ixc, oxc;
        fd_payload_t p;
        va  = (qa.size() > 0);
        vc  = (qc.size() > 0);
        oxa = va && out_ready;
        ixa = in_valid && (qa.size() < 2);
        oxc = vc && out_ready;
        ixc = in_valid && (!vc || out_ready);
        p.addr = in_addr;
        p.inst = in_inst;
        @(posedge clk);
        if (va && !out_ready) begin
            m_stall_a = sat_inc(m_stall_a, 16);
            m_stall_b = sat_inc(m_stall_b, 4);
        end
        if (vc && !out_ready) m_stall_c = sat_inc(m_stall_c, 16);
        if (flush_i) begin
            m_flush_a = sat_inc(m_flush_a, 16);
            m_flush_b = sat_inc(m_flush_b, 4);
            m_flush_c = sat_inc(m_flush_c, 16);
            qa.delete();
            qc.delete();
        end else begin
            if (oxa) void'(qa.pop_front());
            if (ixa) qa.push_back(p);
            if (oxc) void'(qc.pop_front());
            if (ixc) qc.push_back(p);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_addr !== 32'h0 || a_out_inst !== 32'h13 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b addr=%h inst=%h rdy=%0b, want v=0 addr=0 inst=00000013 rdy=1",
                     a_out_valid, a_out_addr, a_out_inst, a_in_ready);
        end
        n_checks++;
        if (a_stall !== 16'd0 || a_flush !== 16'd0 || c_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d c_rdy=%0b, want 0 0 1", a_stall, a_flush, c_in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        // Push A into SKID, then reset between edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 32'hA00; in_inst = $urandom; tick();
        in_addr   = 32'hA04; in_inst = $urandom; tick();
        #1;
        n_checks++;
        if (a_in_ready !== 1'b0 || a_out_addr !== 32'hA00) begin
            n_fail++;
            $display("FAIL reset_setup_skid: got rdy=%0b addr=%h, want rdy=0 addr=00000a00", a_in_ready, a_out_addr);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_addr !== 32'h0 || a_out_inst !== 32'h13 ||
            a_in_ready !== 1'b1 || a_stall !== 16'd0 || a_flush !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_async_midskid: got v=%0b addr=%h inst=%h rdy=%0b stall=%0d flush=%0d, want 0 0 13 1 0 0",
                     a_out_valid, a_out_addr, a_out_inst, a_in_ready, a_stall, a_flush);
        end
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            in_addr  = 32'h100 + 32'(4 * i);
            in_inst  = $urandom;
            #1;
            n_checks++;
            if (a_out_valid !== (qa.size() > 0) || a_out_addr !== ea_addr() || a_out_inst !== ea_inst() || a_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_cyc%0d: got v=%0b addr=%h inst=%h rdy=%0b, want v=%0b addr=%h inst=%h rdy=1",
                         i, a_out_valid, a_out_addr, a_out_inst, a_in_ready, qa.size() > 0, ea_addr(), ea_inst());
            end
            if (i >= 1 && i <= 3) begin
                n_checks++;
                if (a_out_addr !== 32'h100 + 32'(4 * (i - 1))) begin
                    n_fail++;
                    $display("FAIL stream_order%0d: got addr=%h, want %h", i, a_out_addr, 32'h100 + 32'(4 * (i - 1)));
                end
            end
            tick();
        end
        n_checks++;
        if (a_stall !== 16'd0) begin
            n_fail++;
            $display("FAIL stream_stall: got %0d, want 0", a_stall);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 32'h200; in_inst = $urandom; tick();
        in_addr   = 32'h204; in_inst = $urandom; tick();
        in_addr   = 32'h208; in_inst = $urandom;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_addr !== 32'h200 || a_out_inst !== ea_inst()) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got rdy=%0b v=%0b addr=%h inst=%h, want rdy=0 v=1 addr=00000200 inst=%h",
                         i, a_in_ready, a_out_valid, a_out_addr, a_out_inst, ea_inst());
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (a_out_valid !== (i < 2) || a_out_addr !== ((i < 2) ? 32'h200 + 32'(4 * i) : 32'h0) || a_out_inst !== ea_inst()) begin
                n_fail++;
                $display("FAIL bp_drain%0d: got v=%0b addr=%h inst=%h, want v=%0b addr=%h inst=%h",
                         i, a_out_valid, a_out_addr, a_out_inst, i < 2, (i < 2) ? 32'h200 + 32'(4 * i) : 32'h0, ea_inst());
            end
            tick();
        end
        n_checks++;
        if (a_stall !== 16'd4 || a_stall !== 16'(m_stall_a)) begin
            n_fail++;
            $display("FAIL bp_stall_cnt: got %0d, want 4 (model %0d)", a_stall, m_stall_a);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 32'h2A0; in_inst = $urandom; tick();
        in_addr   = 32'h2A4; in_inst = $urandom; tick();
        flush_i   = 1'b1;
        in_addr   = 32'h300; in_inst = $urandom;
        tick();
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_inst !== 32'h13 || a_out_addr !== 32'h0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: got v=%0b addr=%h inst=%h rdy=%0b, want v=0 addr=0 inst=00000013 rdy=1",
                     a_out_valid, a_out_addr, a_out_inst, a_in_ready);
        end
        n_checks++;
        if (a_flush !== 16'd1 || a_stall !== 16'(m_stall_a)) begin
            n_fail++;
            $display("FAIL flush_cnt: got flush=%0d stall=%0d, want flush=1 stall=%0d", a_flush, a_stall, m_stall_a);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (a_out_valid !== 1'b0 || a_out_addr === 32'h300) begin
                n_fail++;
                $display("FAIL flush_no_emit%0d: got v=%0b addr=%h, want v=0", i, a_out_valid, a_out_addr);
            end
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        n_checks++;
        if (a_flush !== 16'd2 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_empty: got flush=%0d v=%0b, want flush=2 v=0", a_flush, a_out_valid);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 32'h400; in_inst = $urandom;
        tick();
        in_valid  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++;
            if (b_stall !== 4'(m_stall_b) || b_out_addr !== 32'h400) begin
                n_fail++;
                $display("FAIL sat_stall%0d: got stall=%0d addr=%h, want stall=%0d addr=00000400", i, b_stall, b_out_addr, m_stall_b);
            end
            tick();
        end
        n_checks++;
        if (b_stall !== 4'hF) begin
            n_fail++;
            $display("FAIL sat_stall_max: got %0d, want 15", b_stall);
        end
        flush_i = 1'b1;
        repeat (16) tick();
        flush_i = 1'b0;
        #1;
        n_checks++;
        if (b_flush !== 4'hF || b_stall !== 4'hF || a_flush !== 16'(m_flush_a)) begin
            n_fail++;
            $display("FAIL sat_flush_max: got b_flush=%0d b_stall=%0d a_flush=%0d, want 15 15 %0d", b_flush, b_stall, a_flush, m_flush_a);
        end
    endtask

    task automatic test_noskid();
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 2 == 0);
            in_addr   = 32'h500 + 32'(4 * i);
            in_inst   = $urandom;
            #1;
            n_checks++;
            if (c_in_ready !== (qc.size() == 0 || out_ready) || c_out_valid !== (qc.size() > 0) ||
                c_out_addr !== ec_addr() || c_out_inst !== ec_inst()) begin
                n_fail++;
                $display("FAIL noskid_cyc%0d: got rdy=%0b v=%0b addr=%h inst=%h, want rdy=%0b v=%0b addr=%h inst=%h",
                         i, c_in_ready, c_out_valid, c_out_addr, c_out_inst,
                         qc.size() == 0 || out_ready, qc.size() > 0, ec_addr(), ec_inst());
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (c_stall !== 16'(m_stall_c)) begin
            n_fail++;
            $display("FAIL noskid_stall: got %0d, want %0d", c_stall, m_stall_c);
        end
    endtask

    task automatic test_random();
        logic [31:0] next_pc = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            if (in_valid && ((qa.size() < 2) || (qc.size() == 0 || out_ready))) next_pc = next_pc + 32'd4;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush_i   = ($urandom_range(24) == 0);
            in_addr   = next_pc;
            in_inst   = $urandom;
            #1;
            n_checks++;
            if (a_in_ready !== (qa.size() < 2) || a_out_valid !== (qa.size() > 0) ||
                a_out_addr !== ea_addr() || a_out_inst !== ea_inst() || a_stall !== 16'(m_stall_a)) begin
                n_fail++;
                $display("FAIL rand_a%0d: got rdy=%0b v=%0b addr=%h inst=%h stall=%0d, want rdy=%0b v=%0b addr=%h inst=%h stall=%0d",
                         i, a_in_ready, a_out_valid, a_out_addr, a_out_inst, a_stall,
                         qa.size() < 2, qa.size() > 0, ea_addr(), ea_inst(), m_stall_a);
            end
            n_checks++;
            if (c_in_ready !== (qc.size() == 0 || out_ready) || c_out_valid !== (qc.size() > 0) ||
                c_out_addr !== ec_addr() || c_out_inst !== ec_inst() || c_flush !== 16'(m_flush_c)) begin
                n_fail++;
                $display("FAIL rand_c%0d: got rdy=%0b v=%0b addr=%h inst=%h flush=%0d, want rdy=%0b v=%0b addr=%h inst=%h flush=%0d",
                         i, c_in_ready, c_out_valid, c_out_addr, c_out_inst, c_flush,
                         qc.size() == 0 || out_ready, qc.size() > 0, ec_addr(), ec_inst(), m_flush_c);
            end
            tick();
        end
        in_valid = 1'b0;
        flush_i  = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_noskid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
